fifo_ctrl: RTL
==============

# fifo_ctrl

FIFO pointer and flag controller that drives the dual-port memory block of the adaptive PCIe switching datapath. It turns a client push/pop handshake into the memory's `write`/`read` strobes and `wr_ptr`/`rd_ptr` addresses, and returns the memory's read data with a valid qualifier. It tracks occupancy, raises full/empty and programmable almost-full/almost-empty flags, and latches overflow/underflow as a sticky error. One `fifo_ctrl` plus one memory instance form each per-lane FIFO.

## Interface
- MAIN_SIZE, 3, address width; depth = 2^MAIN_SIZE entries
- DATA_SIZE, 10, data word width
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- push  in  1  write request; data_in is captured when accepted
- data_in  in  DATA_SIZE  write data
- pop  in  1  read request
- af_thresh  in  MAIN_SIZE+1  almost-full threshold, latched in INIT
- ae_thresh  in  MAIN_SIZE+1  almost-empty threshold, latched in INIT
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- wr_ptr  out  MAIN_SIZE  memory write address
- rd_ptr  out  MAIN_SIZE  memory read address
- mem_data_in  out  DATA_SIZE  memory write data; equals data_in
- mem_data_out  in  DATA_SIZE  registered memory read data, valid one cycle after mem_read
- data_out  out  DATA_SIZE  popped word
- valid_out  out  1  data_out qualifier
- count  out  MAIN_SIZE+1  occupancy, range 0..2^MAIN_SIZE
- full, empty, almost_full, almost_empty  out  1  status flags
- error  out  1  sticky overflow/underflow

## Operation
- FSM states:
  - INIT: entered from reset. For one cycle it latches af_thresh/ae_thresh, ignores push/pop and goes to ACTIVE.
  - ACTIVE: normal operation.
  - ERROR: holds all state and blocks push/pop; exits only via reset.
- Accept rules (ACTIVE):
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
  - mem_write = push_ok; mem_read = pop_ok. Both are combinational, and both are 0 while reset=1 or state≠ACTIVE.
- Overflow (push & full & ~pop) or underflow (pop & empty) in ACTIVE:
  - next state ERROR, error=1;
  - no strobe is issued that cycle, including the other request.
- Simultaneous push+pop:
  - When full: both accepted, count unchanged. The memory is read-before-write, so the oldest word is returned.
  - When empty: underflow, which takes the error path above.
- Pointer and count updates:
  - wr_ptr increments on push_ok; rd_ptr increments on pop_ok.
  - Both wrap modulo 2^MAIN_SIZE, with no extra wrap bit.
  - count += push_ok − pop_ok.
- Flags are derived from registered count and latched thresholds:
  - full = (count == 2^MAIN_SIZE); empty = (count == 0)
  - almost_full = (count ≥ af_thr); almost_empty = (count ≤ ae_thr)
- data_out = valid_out ? mem_data_out : 0.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, valid_out=0, data_out=0, error=0, mem_write=0, mem_read=0, latched thresholds=0, state=INIT.
- Reset asserted mid-operation clears everything above at the next edge; FIFO contents are discarded logically.
- Write: data is stored at the edge where push_ok=1. count/flags reflect it after that edge.
- Read latency 1: pop_ok at edge N → valid_out=1 and data_out valid during the cycle after N. Back-to-back pops stream one word per cycle.
- First push accepted: second edge after reset deasserts, because the first cycle is INIT.
- Error: error rises at the edge after the offending request and stays high.

## Structure
- Shared package `fifo_pkg`:
  - FSM state encoding (INIT, ACTIVE, ERROR);
  - default MAIN_SIZE/DATA_SIZE constants;
  - a DEPTH = 2^MAIN_SIZE constant.
- Sub-module `fifo_flags`: registered count, thresholds and flag comparators.
- Top `fifo_ctrl` holds the FSM, pointers, strobes and read-valid pipeline.
- Bench instantiates `fifo_ctrl` with the existing memory block as a 1-cycle-latency read-before-write dual-port RAM.

## Test plan
- Fill: reset, af_thresh=6, ae_thresh=1, push data 1..8 on consecutive cycles → almost_full rises after the 6th push, full=1 and count=8 after the 8th, wr_ptr=0 (wrapped).
- Drain: pop 8 times → valid_out=1 and data_out=1..8 in order, one cycle after each pop. empty=1, almost_empty=1, rd_ptr=0, error=0.
- Wrap: push 5, pop 5, then push 8 words 20..27, then pop all → data 20..27 in order across the pointer wrap, count returns 0.
- Full push+pop: fill with 1..8, push 9 together with pop → data_out=1, count stays 8, full stays 1, error=0. The next pops return 2..9.
- Overflow and underflow:
  - Full, push without pop → error=1 next cycle, no mem_write. A later pop gives mem_read=0.
  - After reset, pop on empty (with or without push) → error=1.
- Reset mid-operation: count=4, assert reset for 1 cycle → all outputs at reset values. After INIT, push 7 then pop returns 7.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the per-lane FIFO controller: state encoding and
// default geometry of the pointer/flag logic.
package fifo_pkg;

    localparam int MAIN_SIZE_DEF = 3;
    localparam int DATA_SIZE_DEF = 10;
    localparam int DEPTH         = 2 ** MAIN_SIZE_DEF;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fifo_flags.sv
// Occupancy counter, latched almost-full/almost-empty thresholds and the
// registered status flags of one FIFO lane.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int MAIN_SIZE = MAIN_SIZE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch_thr,
    input  logic             push_ok,
    input  logic             pop_ok,
    input  logic [MAIN_SIZE:0] af_thresh,
    input  logic [MAIN_SIZE:0] ae_thresh,
    output logic [MAIN_SIZE:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam logic [MAIN_SIZE:0] FULL_CNT = {1'b1, {MAIN_SIZE{1'b0}}};
    localparam logic [MAIN_SIZE:0] CNT_ONE  = (MAIN_SIZE + 1)'(1);

    logic [MAIN_SIZE:0] count_r;
    logic [MAIN_SIZE:0] af_thr_r;
    logic [MAIN_SIZE:0] ae_thr_r;
    logic [MAIN_SIZE:0] count_nxt_s;
    logic [MAIN_SIZE:0] af_thr_nxt_s;
    logic [MAIN_SIZE:0] ae_thr_nxt_s;
    logic               full_r;
    logic               empty_r;
    logic               af_r;
    logic               ae_r;

    // Next occupancy and thresholds; flags are registered from these so they
    // always agree with the count visible in the same cycle.
    always_comb begin
        count_nxt_s  = count_r;
        af_thr_nxt_s = af_thr_r;
        ae_thr_nxt_s = ae_thr_r;
        if (push_ok && !pop_ok) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
        if (latch_thr) begin
            af_thr_nxt_s = af_thresh;
            ae_thr_nxt_s = ae_thresh;
        end else begin
            af_thr_nxt_s = af_thr_r;
            ae_thr_nxt_s = ae_thr_r;
        end
    end

    // Count, threshold and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= {(MAIN_SIZE + 1){1'b0}};
            af_thr_r <= {(MAIN_SIZE + 1){1'b0}};
            ae_thr_r <= {(MAIN_SIZE + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
        end else begin
            count_r  <= count_nxt_s;
            af_thr_r <= af_thr_nxt_s;
            ae_thr_r <= ae_thr_nxt_s;
            full_r   <= (count_nxt_s == FULL_CNT);
            empty_r  <= (count_nxt_s == {(MAIN_SIZE + 1){1'b0}});
            af_r     <= (count_nxt_s >= af_thr_nxt_s);
            ae_r     <= (count_nxt_s <= ae_thr_nxt_s);
        end
    end

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/strobe controller: turns push/pop into memory write/read
// strobes and addresses, qualifies returned data and traps misuse.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int MAIN_SIZE = MAIN_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [MAIN_SIZE:0]   af_thresh,
    input  logic [MAIN_SIZE:0]   ae_thresh,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [DATA_SIZE-1:0] mem_data_in,
    input  logic [DATA_SIZE-1:0] mem_data_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [MAIN_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam logic [MAIN_SIZE-1:0] PTR_ONE = MAIN_SIZE'(1);

    fifo_state_e          state_r;
    logic [MAIN_SIZE-1:0] wr_ptr_r;
    logic [MAIN_SIZE-1:0] rd_ptr_r;
    logic                 valid_r;
    logic                 error_r;
    logic                 fault_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;
    logic                 latch_thr_s;
    logic                 full_s;
    logic                 empty_s;

    // Accept decode: a faulting request suppresses both strobes that cycle.
    always_comb begin
        fault_s   = 1'b0;
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (!reset && (state_r == ST_ACTIVE)) begin
            fault_s = (push & full_s & ~pop) | (pop & empty_s);
            if (fault_s) begin
                push_ok_s = 1'b0;
                pop_ok_s  = 1'b0;
            end else begin
                push_ok_s = push & (~full_s | pop);
                pop_ok_s  = pop & ~empty_s;
            end
        end else begin
            fault_s   = 1'b0;
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end
    end

    assign latch_thr_s = !reset && (state_r == ST_INIT);

    // Control FSM with pointers, sticky error and the read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_INIT;
            wr_ptr_r <= {MAIN_SIZE{1'b0}};
            rd_ptr_r <= {MAIN_SIZE{1'b0}};
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    state_r <= ST_ACTIVE;
                    valid_r <= 1'b0;
                end
                ST_ACTIVE: begin
                    if (fault_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                    if (push_ok_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    end
                    if (pop_ok_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    end
                    valid_r <= pop_ok_s;
                end
                ST_ERROR: begin
                    valid_r <= 1'b0;
                end
                default: begin
                    // An unreachable encoding is treated as a fault.
                    state_r <= ST_ERROR;
                    error_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    fifo_flags #(
        .MAIN_SIZE (MAIN_SIZE)
    ) u_flags (
        .clk          (clk),
        .reset        (reset),
        .latch_thr    (latch_thr_s),
        .push_ok      (push_ok_s),
        .pop_ok       (pop_ok_s),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .full         (full_s),
        .empty        (empty_s),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    assign full        = full_s;
    assign empty       = empty_s;
    assign mem_write   = push_ok_s;
    assign mem_read    = pop_ok_s;
    assign wr_ptr      = wr_ptr_r;
    assign rd_ptr      = rd_ptr_r;
    assign mem_data_in = data_in;
    assign valid_out   = valid_r;
    assign error       = error_r;
    assign data_out    = valid_r ? mem_data_out : {DATA_SIZE{1'b0}};

endmodule
